// File: rtl/prng_sched_if.sv
// prng_sched_if: bundles the requester, configuration and generator-side
// signals of the PRNG scheduler. The slave modport is the scheduler's view;
// the master modport is the view of the environment (requesters, config
// bus and the external generator together).
interface prng_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rn_out;
    logic             rn_valid;
    logic             cfg_seed_we;
    logic [WIDTH-1:0] cfg_seed;
    logic             gen_load;
    logic [WIDTH-1:0] gen_seed;
    logic             gen_step;
    logic [WIDTH-1:0] gen_rn;
    logic             busy;

    modport slave (
        input  req, cfg_seed_we, cfg_seed, gen_rn,
        output gnt, rn_out, rn_valid, gen_load, gen_seed, gen_step, busy
    );

    modport master (
        output req, cfg_seed_we, cfg_seed, gen_rn,
        input  gnt, rn_out, rn_valid, gen_load, gen_seed, gen_step, busy
    );
endinterface

// File: rtl/prng_sched.sv
// prng_sched: round-robin scheduler that shares one external random-number
// generator between NREQ requesters. It seeds the generator after reset and
// after every seed write, steps it once per granted request, waits GEN_LAT
// cycles for the word and delivers it with a one-cycle grant pulse.
//
// Optional feature: define PRNG_SCHED_ZERO_GUARD_EN to re-seed and re-step
// once when the generator returns an all-zero word (a second zero is
// delivered as-is). Without the macro, zero words are ordinary words and no
// retry logic exists.
module prng_sched #(
    parameter int               NREQ    = 4,
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] SEED    = 16'h00a3,
    parameter int               GEN_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    prng_sched_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = IW + 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] seed_q;
    logic [IW-1:0]    ptr_q;      // first index searched on the next arbitration
    logic [IW-1:0]    winner_q;
    logic             pend_q;     // seed written, generator not yet reloaded
    logic [2:0]       wait_cnt_q;
    logic [WIDTH-1:0] rn_out_q;
    logic             rn_valid_q;
    logic [NREQ-1:0]  gnt_q;
    logic             gen_load_q;
    logic             gen_step_q;
    logic             busy_q;
`ifdef PRNG_SCHED_ZERO_GUARD_EN
    logic             retry_q;    // the current request already re-stepped once
`endif

    logic             found;
    logic [IW-1:0]    pick;
    logic [SW-1:0]    sum;
    logic [IW-1:0]    cand;

    // Round-robin search: first requester at or after ptr_q, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + SW'(i);
            if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
            cand = sum[IW-1:0];
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Scheduler FSM; every output is a register updated here.
    // NOTE: reset is asynchronous, so every register, including the
    // datapath word, gets a defined value in the reset branch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            seed_q     <= SEED;
            ptr_q      <= '0;
            winner_q   <= '0;
            pend_q     <= 1'b0;
            wait_cnt_q <= '0;
            rn_out_q   <= '0;
            rn_valid_q <= 1'b0;
            gnt_q      <= '0;
            gen_load_q <= 1'b0;
            gen_step_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef PRNG_SCHED_ZERO_GUARD_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking defaults make every pulse one cycle long;
            // a later assignment in the same edge overrides the default.
            gen_load_q <= 1'b0;
            gen_step_q <= 1'b0;
            rn_valid_q <= 1'b0;
            gnt_q      <= '0;

            // Seed writes are accepted in every state.
            if (bus.cfg_seed_we) begin
                seed_q <= bus.cfg_seed;
                pend_q <= 1'b1;
            end

            case (state)
                S_LOAD: begin
                    if (!gen_load_q) begin
                        // Entered from reset: issue the load pulse now.
                        gen_load_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
`ifdef PRNG_SCHED_ZERO_GUARD_EN
                        if (retry_q) begin
                            state      <= S_STEP;
                            gen_step_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
`endif
                    end
                end

                S_IDLE: begin
                    if (pend_q) begin
                        // Entering LOAD clears the flag unless a write lands now.
                        state      <= S_LOAD;
                        gen_load_q <= 1'b1;
                        busy_q     <= 1'b1;
                        pend_q     <= bus.cfg_seed_we;
                    end else if (found) begin
                        winner_q   <= pick;
                        state      <= S_STEP;
                        gen_step_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end

                S_STEP: begin
                    state      <= S_WAIT;
                    wait_cnt_q <= 3'(GEN_LAT - 1);
                end

                S_WAIT: begin
                    if (wait_cnt_q != 3'd0) begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end else begin
                        // Outputs are registered, so the winner's req is
                        // checked on the edge that enters DELIVER.
                        state <= S_DELIVER;
                        if (bus.req[winner_q]) begin
                            rn_out_q   <= bus.gen_rn;
                            rn_valid_q <= 1'b1;
                            gnt_q      <= NREQ'(1) << winner_q;
                        end
`ifdef PRNG_SCHED_ZERO_GUARD_EN
                        if (bus.gen_rn == '0 && !retry_q) begin
                            state      <= S_LOAD;
                            gen_load_q <= 1'b1;
                            pend_q     <= bus.cfg_seed_we;
                            retry_q    <= 1'b1;
                            rn_out_q   <= rn_out_q;
                            rn_valid_q <= 1'b0;
                            gnt_q      <= '0;
                        end
`endif
                    end
                end

                S_DELIVER: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    ptr_q  <= (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + IW'(1);
`ifdef PRNG_SCHED_ZERO_GUARD_EN
                    retry_q <= 1'b0;
`endif
                end

                default: begin
                    state  <= S_LOAD;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rn_out   = rn_out_q;
    assign bus.rn_valid = rn_valid_q;
    assign bus.gen_load = gen_load_q;
    assign bus.gen_seed = seed_q;
    assign bus.gen_step = gen_step_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_prng_sched.sv
// tb_prng_sched: directed test of prng_sched with GEN_LAT=1. The bench plays
// both the requesters and the external generator (gen_rn driven directly).
// Cycle n means the interval after the n-th rising edge; inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_prng_sched;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [15:0] last_rn;

    prng_sched_if #(.NREQ(4), .WIDTH(16)) bus ();

    prng_sched #(
        .NREQ(4), .WIDTH(16), .SEED(16'h00a3), .GEN_LAT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset for one edge, release, and check the seeding sequence.
    // Returns in cycle 2 (IDLE). req is left as the caller set it.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        check("rst_busy",     bus.busy,     1);
        check("rst_gen_load", bus.gen_load, 0);
        check("rst_gen_step", bus.gen_step, 0);
        check("rst_rn_valid", bus.rn_valid, 0);
        check("rst_gnt",      bus.gnt,      0);
        check("rst_rn_out",   bus.rn_out,   0);
        check("rst_seed",     bus.gen_seed, 16'h00a3);
        rst = 1'b0;
        tick();
        check("c1_gen_load", bus.gen_load, 1);
        check("c1_busy",     bus.busy,     1);
        check("c1_gen_step", bus.gen_step, 0);
        tick();
        check("c2_gen_load", bus.gen_load, 0);
        check("c2_busy",     bus.busy,     0);
        check("c2_gen_step", bus.gen_step, 0);
        check("c2_seed",     bus.gen_seed, 16'h00a3);
    endtask

    // Wait (bounded) for a delivery, check it, then drop the granted bit.
    task automatic wait_grant(input string tag, input logic [3:0] eg,
                              input logic [15:0] er, input int el);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == 4'b0 && !bus.rn_valid && n < 20);
        check({tag, "_lat"},   n,            el);
        check({tag, "_gnt"},   bus.gnt,      eg);
        check({tag, "_valid"}, bus.rn_valid, 1);
        check({tag, "_rn"},    bus.rn_out,   er);
        bus.req = bus.req & ~bus.gnt;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_checks = 0;
        n_fail   = 0;
        rst             = 1'b1;
        bus.req         = '0;
        bus.cfg_seed_we = 1'b0;
        bus.cfg_seed    = '0;
        bus.gen_rn      = '0;

        // Reset state and seeding after release.
        do_reset();

        // Single request, GEN_LAT=1: gen_step in cycle 1, delivery in cycle 3.
        bus.req    = 4'b0001;
        bus.gen_rn = 16'h1234;
        tick();
        check("t1_gen_step1", bus.gen_step, 1);
        check("t1_busy1",     bus.busy,     1);
        check("t1_gnt1",      bus.gnt,      0);
        tick();
        check("t1_gen_step2", bus.gen_step, 0);
        check("t1_valid2",    bus.rn_valid, 0);
        tick();
        check("t1_gnt3",   bus.gnt,      4'b0001);
        check("t1_valid3", bus.rn_valid, 1);
        check("t1_rn3",    bus.rn_out,   16'h1234);
        bus.req = '0;
        tick();
        check("t1_valid4", bus.rn_valid, 0);
        check("t1_gnt4",   bus.gnt,      0);
        check("t1_hold4",  bus.rn_out,   16'h1234);
        check("t1_busy4",  bus.busy,     0);

        // Round robin from a fresh reset with all four requesting.
        do_reset();
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            bus.gen_rn = 16'h1000 + 16'(n);
            wait_grant("rr", rr_exp[n], 16'h1000 + 16'(n), 3);
            tick();
            bus.req = (n < 4) ? 4'b1111 : 4'b0000;
        end

        // Seed write during WAIT: current grant completes, then reload.
        bus.req    = 4'b0001;
        bus.gen_rn = 16'h4321;
        tick();
        check("rs_step", bus.gen_step, 1);
        tick();
        bus.cfg_seed_we = 1'b1;
        bus.cfg_seed    = 16'hbeef;
        tick();
        bus.cfg_seed_we = 1'b0;
        check("rs_gnt",   bus.gnt,      4'b0001);
        check("rs_valid", bus.rn_valid, 1);
        check("rs_rn",    bus.rn_out,   16'h4321);
        check("rs_seed",  bus.gen_seed, 16'hbeef);
        bus.req    = 4'b0010;
        bus.gen_rn = 16'h5555;
        tick();
        check("rs_idle_load", bus.gen_load, 0);
        tick();
        check("rs_load",      bus.gen_load, 1);
        check("rs_load_step", bus.gen_step, 0);
        check("rs_load_seed", bus.gen_seed, 16'hbeef);
        wait_grant("rs_next", 4'b0010, 16'h5555, 4);
        last_rn = 16'h5555;

        // Winner drops req during WAIT: discarded, pointer still advances.
        bus.req    = 4'b0100;
        bus.gen_rn = 16'h7777;
        tick();
        tick();
        check("dr_step", bus.gen_step, 1);
        tick();
        bus.req = 4'b0000;
        tick();
        check("dr_gnt",   bus.gnt,      0);
        check("dr_valid", bus.rn_valid, 0);
        check("dr_hold",  bus.rn_out,   last_rn);
        tick();
        check("dr_idle", bus.busy, 0);
        bus.req = 4'b1100;
        wait_grant("dr_next", 4'b1000, 16'h7777, 3);
        bus.req = 4'b0000;
        tick();

        // Reset in mid-transaction: no grant, seed restored, req held through.
        bus.req    = 4'b0001;
        bus.gen_rn = 16'h2222;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mr_gnt",   bus.gnt,      0);
        check("mr_valid", bus.rn_valid, 0);
        check("mr_busy",  bus.busy,     1);
        do_reset();
        tick();
        check("mr_step3", bus.gen_step, 1);
        wait_grant("mr_grant", 4'b0001, 16'h2222, 2);
        tick();

        // All-zero generator word.
        bus.req    = 4'b0001;
        bus.gen_rn = 16'h0000;
        tick();
        check("z_step", bus.gen_step, 1);
        tick();
        tick();
`ifdef PRNG_SCHED_ZERO_GUARD_EN
        check("z_reload", bus.gen_load, 1);
        check("z_novalid", bus.rn_valid, 0);
        bus.gen_rn = 16'h5a5a;
        tick();
        check("z_restep", bus.gen_step, 1);
        tick();
        tick();
        check("z_gnt",   bus.gnt,      4'b0001);
        check("z_valid", bus.rn_valid, 1);
        check("z_rn",    bus.rn_out,   16'h5a5a);
`else
        check("z_gnt",   bus.gnt,      4'b0001);
        check("z_valid", bus.rn_valid, 1);
        check("z_rn",    bus.rn_out,   16'h0000);
        bus.gen_rn = 16'h5a5a;
`endif
        bus.req = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
